// File: rtl/fft_sdf_pkg.sv
// rtl/fft_sdf_pkg.sv - shared constants, constant functions and state type for the R2SDF sequencer
// Provides: LOG2N_DEF, N_DEF, L_DEF, n_pts(), latency(), stage_delay(), stage_off(),
//           bitrev(), state_t {S_IDLE, S_RUN, S_FLUSH}.
package fft_sdf_pkg;

  localparam int LOG2N_DEF = 4;

  function automatic int n_pts(input int log2n);
    return 1 << log2n;
  endfunction

  // End-to-end latency: all delay lines (N-1 total) plus one register per stage.
  function automatic int latency(input int log2n);
    return n_pts(log2n) - 1 + log2n;
  endfunction

  // Feedback delay length of stage s.
  function automatic int stage_delay(input int log2n, input int s);
    return n_pts(log2n) >> (s + 1);
  endfunction

  // Slot offset at which stage s first sees a sample that entered stage 0 at slot 0.
  function automatic int stage_off(input int log2n, input int s);
    int o;
    o = 0;
    for (int j = 0; j < s; j++) o += stage_delay(log2n, j) + 1;
    return o;
  endfunction

  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < w; i++) r[i] = v[w-1-i];
    return r;
  endfunction

  localparam int N_DEF = n_pts(LOG2N_DEF);
  localparam int L_DEF = latency(LOG2N_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/fft_sdf_vpipe.sv
// rtl/fft_sdf_vpipe.sv - valid-tracking shift register mirroring the pipeline occupancy
// Ports: clk, reset (async, active-high), en (advance), din (entering valid bit),
//        last (oldest bit, about to leave), next_empty (register is all zero after this shift).
module fft_sdf_vpipe #(
  parameter int L = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic din,
  output logic last,
  output logic next_empty
);

  logic [L-1:0] q;
  logic [L-1:0] d;

  assign d = {q[L-2:0], din};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

  assign last = q[L-1];
  // Only consulted on shift cycles, so it looks at the post-shift value.
  assign next_empty = (d == '0);

endmodule

// File: rtl/fft_sdf_ctrl.sv
// rtl/fft_sdf_ctrl.sv - sequencer for a radix-2 SDF DIF FFT pipeline of 2^LOG2N points
// Ports: clk, reset (async, active-high); in_valid/in_ready input handshake;
//        shift_en, zero_in, sel[LOG2N], tw_addr[(LOG2N-1)^2] to the datapath;
//        out_valid, out_index, frame_done output labelling; busy (state != IDLE).
module fft_sdf_ctrl
  import fft_sdf_pkg::*;
#(
  parameter int LOG2N = LOG2N_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic                           shift_en,
  output logic                           zero_in,
  output logic [LOG2N-1:0]               sel,
  output logic [(LOG2N-1)*(LOG2N-1)-1:0] tw_addr,
  output logic                           out_valid,
  output logic [LOG2N-1:0]               out_index,
  output logic                           frame_done,
  output logic                           busy
);

  localparam int N  = n_pts(LOG2N);
  localparam int L  = latency(LOG2N);
  localparam int TW = LOG2N - 1;

  state_t           state;
  logic [LOG2N-1:0] g;
  logic [LOG2N-1:0] out_cnt;
  logic             accept;
  logic             flushing;
  logic             active;
  logic             vp_last;
  logic             vp_empty;
  logic [LOG2N-1:0] sel_raw;
  logic [TW*TW-1:0] tw_raw;

  assign in_ready = (state != S_FLUSH);
  // Reset dominates so nothing advances while it is held.
  assign accept   = in_valid & in_ready & ~reset;
  // A gap at a frame boundary starts the flush in the same cycle, so the
  // flush covers exactly L shifts after the final sample.
  assign flushing = (state == S_FLUSH) | ((state == S_RUN) & ~in_valid & (g == '0));
  assign shift_en = accept | flushing;
  assign zero_in  = flushing;
  assign busy     = (state != S_IDLE);
  // Stage controls are parked at zero while the pipeline sits idle.
  assign active   = busy | accept;

  // Stage s only needs the low LOG2N-s bits of (g - off_s): the top one is
  // its fill/compute select, the rest is the phase modulo D_s.
  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int             W   = LOG2N - s;
    localparam logic [W-1:0]   OFF = W'(stage_off(LOG2N, s));
    logic [W-1:0] ph;
    assign ph         = g[W-1:0] - OFF;
    assign sel_raw[s] = ph[W-1];
    if (s < LOG2N - 1) begin : g_tw
      assign tw_raw[s*TW +: TW] = TW'(ph[W-2:0]) << s;
    end
  end

  assign sel     = active ? sel_raw : '0;
  assign tw_addr = active ? tw_raw  : '0;

  fft_sdf_vpipe #(.L(L)) u_vpipe (
    .clk        (clk),
    .reset      (reset),
    .en         (shift_en),
    .din        (accept),
    .last       (vp_last),
    .next_empty (vp_empty)
  );

  assign out_valid  = shift_en & vp_last;
  assign out_index  = LOG2N'(bitrev(32'(out_cnt), LOG2N));
  assign frame_done = out_valid & (out_cnt == LOG2N'(N - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      g       <= '0;
      out_cnt <= '0;
    end else begin
      if (shift_en)  g       <= g + 1'b1;
      if (out_valid) out_cnt <= out_cnt + 1'b1;
      case (state)
        S_IDLE: if (accept) state <= S_RUN;
        S_RUN, S_FLUSH: begin
          if (flushing) begin
            if (vp_empty) begin
              // Pipeline drained: realign the slot counter for the next frame.
              state <= S_IDLE;
              g     <= '0;
            end else begin
              state <= S_FLUSH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// tb/tb_fft_sdf_ctrl.sv - directed self-checking bench for fft_sdf_ctrl (LOG2N=4)
module tb_fft_sdf_ctrl;

  localparam int LOG2N = 4;
  localparam int NP    = 16;
  localparam int LAT   = 19;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready, shift_en, zero_in, out_valid, frame_done, busy;
  logic [3:0] sel, out_index;
  logic [8:0] tw_addr;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;

  fft_sdf_ctrl #(.LOG2N(LOG2N)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .shift_en   (shift_en),
    .zero_in    (zero_in),
    .sel        (sel),
    .tw_addr    (tw_addr),
    .out_valid  (out_valid),
    .out_index  (out_index),
    .frame_done (frame_done),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
  endtask

  function automatic int off_of(input int s);
    case (s)
      0: return 0;
      1: return 9;
      2: return 14;
      default: return 17;
    endcase
  endfunction

  function automatic logic [3:0] exp_sel(input int gv);
    logic [3:0] r;
    int ph;
    for (int s = 0; s < 4; s++) begin
      ph = (gv - off_of(s) + 32) % 16;
      r[s] = ((ph >> (3 - s)) & 1) != 0;
    end
    return r;
  endfunction

  function automatic logic [8:0] exp_tw(input int gv);
    logic [8:0] r;
    int ph, d;
    for (int s = 0; s < 3; s++) begin
      ph = (gv - off_of(s) + 32) % 16;
      d  = 8 >> s;
      r[s*3 +: 3] = 3'((ph % d) << s);
    end
    return r;
  endfunction

  function automatic logic [3:0] rev4(input int v);
    logic [3:0] a, r;
    a = 4'(v);
    for (int i = 0; i < 4; i++) r[i] = a[3-i];
    return r;
  endfunction

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  32'(in_ready),   32'(1));
    check({tag, "_shift_en"},  32'(shift_en),   32'(0));
    check({tag, "_zero_in"},   32'(zero_in),    32'(0));
    check({tag, "_out_valid"}, 32'(out_valid),  32'(0));
    check({tag, "_frame_done"},32'(frame_done), 32'(0));
    check({tag, "_busy"},      32'(busy),       32'(0));
    check({tag, "_sel"},       32'(sel),        32'(0));
    check({tag, "_tw_addr"},   32'(tw_addr),    32'(0));
    check({tag, "_out_index"}, 32'(out_index),  32'(0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one frame of nsamp samples, optionally stalling stall_len cycles
  // when stall_g samples have been taken, optionally holding in_valid high
  // through the flush, optionally resetting at cycle abort_at.
  task automatic run_frame(input int nsamp, input int stall_g, input int stall_len,
                           input bit hold, input int abort_at);
    int k, c, stall_left, last;
    bit v, sh;
    k = 0;
    c = 0;
    stall_left = stall_len;
    last = nsamp + LAT - 1;
    while (k <= last) begin
      if (c == abort_at) begin
        @(negedge clk);
        reset = 1'b1;
        in_valid = 1'b0;
        #1;
        cyc = c;
        check_reset_vals("abort");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          #1;
          check("abort_out_valid", 32'(out_valid), 32'(0));
          check("abort_busy", 32'(busy), 32'(0));
        end
        return;
      end
      sh = 1'b1;
      if (k > nsamp) v = hold;
      else if (k == stall_g && stall_left > 0) begin
        v = 1'b0;
        sh = 1'b0;
        stall_left--;
      end else v = (k < nsamp);
      @(negedge clk);
      in_valid = v;
      #1;
      cyc = c;
      check("shift_en",   32'(shift_en),   32'(sh));
      check("zero_in",    32'(zero_in),    32'(sh && k >= nsamp));
      check("in_ready",   32'(in_ready),   32'(!(k > nsamp)));
      check("busy",       32'(busy),       32'(k > 0));
      check("out_valid",  32'(out_valid),  32'(sh && k >= LAT));
      check("frame_done", 32'(frame_done), 32'(sh && k >= LAT && ((k - LAT) % NP) == NP - 1));
      if (sh && k >= LAT) check("out_index", 32'(out_index), 32'(rev4(k - LAT)));
      check("sel",     32'(sel),     (k > 0 || v) ? 32'(exp_sel(k % NP)) : 32'(0));
      check("tw_addr", 32'(tw_addr), (k > 0 || v) ? 32'(exp_tw(k % NP))  : 32'(0));
      if (sh) k++;
      c++;
    end
    // First cycle after the last output leaves: controller is back in IDLE.
    @(negedge clk);
    in_valid = hold;
    #1;
    cyc = c;
    check("end_busy",      32'(busy),      32'(0));
    check("end_in_ready",  32'(in_ready),  32'(1));
    check("end_zero_in",   32'(zero_in),   32'(0));
    check("end_out_valid", 32'(out_valid), 32'(0));
    check("end_shift_en",  32'(shift_en),  32'(hold));
    check("end_sel",       32'(sel),       hold ? 32'(exp_sel(0)) : 32'(0));
    check("end_tw_addr",   32'(tw_addr),   hold ? 32'(exp_tw(0))  : 32'(0));
    if (hold) begin
      // That sample was taken at g=0, so a stall now sits at g=1.
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      cyc = c + 1;
      check("post_stall_shift", 32'(shift_en), 32'(0));
      check("post_busy",        32'(busy),     32'(1));
      check("post_tw_addr",     32'(tw_addr),  32'(exp_tw(1)));
      check("post_sel",         32'(sel),      32'(exp_sel(1)));
      pulse_reset();
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_vals("reset");
    @(negedge clk);
    reset = 1'b0;

    run_frame(16, -1, 0, 1'b0, -1);
    run_frame(16,  5, 3, 1'b0, -1);
    run_frame(32, -1, 0, 1'b0, -1);
    run_frame(16, -1, 0, 1'b1, -1);
    run_frame(16, -1, 0, 1'b0, 25);
    run_frame(16, -1, 0, 1'b0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
